// File: rtl/counter_rr_sched.sv
// Round-robin scheduler owning four shared counters (SIZE, SIZE/2, SIZE/2, SIZE/4) and their registered sum.
// Optional starvation monitor enabled by defining COUNTER_RR_SCHED_STARVE_MON_EN.
module counter_rr_sched #(
    parameter int SIZE         = 8,
    parameter int QUANTUM      = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [3:0]          req,
    input  logic                wrap_clr,
    output logic [3:0]          grant,
    output logic                grant_vld,
    output logic [SIZE-1:0]     val1,
    output logic [SIZE/2-1:0]   val2,
    output logic [SIZE/2-1:0]   val3,
    output logic [SIZE/4-1:0]   val4,
    output logic [3:0]          wrap,
    output logic [2*SIZE-1:0]   sum
`ifdef COUNTER_RR_SCHED_STARVE_MON_EN
    ,
    output logic [3:0]          starve
`endif
);

    localparam int         SW   = 2 * SIZE;
    localparam logic [3:0] QMAX = 4'(QUANTUM);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] w_q, w_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] qcnt_q, qcnt_d;
    logic [3:0] grant_d;
    logic [3:0] inc;
    logic [3:0] wrap_set;

    // First set request bit at or after 'from', wrapping around.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] idx;
        logic       found;
        rr_pick = from;
        found   = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = from + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        ptr_d   = ptr_q;
        qcnt_d  = qcnt_q;
        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    state_d = BUSY;
                    w_d     = rr_pick(req, ptr_q);
                    qcnt_d  = 4'd1;
                end
            end
            BUSY: begin
                if (!en) begin
                    state_d = IDLE;
                    ptr_d   = w_q + 2'd1;
                    qcnt_d  = '0;
                end else if (req[w_q] && (qcnt_q < QMAX)) begin
                    qcnt_d = qcnt_q + 4'd1;
                end else begin
                    // Rotation and re-arbitration share one cycle so grants run back-to-back.
                    ptr_d = w_q + 2'd1;
                    if (|req) begin
                        w_d    = rr_pick(req, w_q + 2'd1);
                        qcnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        qcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_d = '0;
        if (state_d == BUSY) begin
            grant_d[w_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            ptr_q   <= '0;
            qcnt_q  <= '0;
            grant   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            ptr_q   <= ptr_d;
            qcnt_q  <= qcnt_d;
            grant   <= grant_d;
        end
    end

    assign grant_vld = |grant;

    // Registered grant already encodes the active winner; enable gates the increment.
    assign inc = en ? grant : 4'b0000;

    always_comb begin
        wrap_set    = '0;
        wrap_set[0] = inc[0] && (val1 == '1);
        wrap_set[1] = inc[1] && (val2 == '1);
        wrap_set[2] = inc[2] && (val3 == '1);
        wrap_set[3] = inc[3] && (val4 == '1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val1 <= '0;
            val2 <= '0;
            val3 <= '0;
            val4 <= '0;
            wrap <= '0;
            sum  <= '0;
        end else begin
            if (inc[0]) val1 <= val1 + SIZE'(1);
            if (inc[1]) val2 <= val2 + (SIZE/2)'(1);
            if (inc[2]) val3 <= val3 + (SIZE/2)'(1);
            if (inc[3]) val4 <= val4 + (SIZE/4)'(1);
            wrap <= (wrap & ~{4{wrap_clr}}) | wrap_set;
            sum  <= SW'(val1) + SW'(val2) + SW'(val3) + SW'(val4);
        end
    end

`ifdef COUNTER_RR_SCHED_STARVE_MON_EN
    localparam int          WW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);

    logic [WW-1:0] wait_cnt [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (req[i] && !grant[i]) begin
                    if (wait_cnt[i] < LIM) wait_cnt[i] <= wait_cnt[i] + WW'(1);
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            starve[i] = (wait_cnt[i] >= LIM);
        end
    end
`endif

endmodule

// File: tb/tb_counter_rr_sched.sv
// Self-checking bench for counter_rr_sched: vector table, corner-case sequences and randomized model comparison.
module tb_counter_rr_sched;

    localparam int SIZE         = 8;
    localparam int QUANTUM      = 2;
    localparam int STARVE_LIMIT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [3:0]          req;
    logic                wrap_clr;
    logic [3:0]          grant;
    logic                grant_vld;
    logic [SIZE-1:0]     val1;
    logic [SIZE/2-1:0]   val2;
    logic [SIZE/2-1:0]   val3;
    logic [SIZE/4-1:0]   val4;
    logic [3:0]          wrap;
    logic [2*SIZE-1:0]   sum;
`ifdef COUNTER_RR_SCHED_STARVE_MON_EN
    logic [3:0]          starve;
`endif

    counter_rr_sched #(
        .SIZE(SIZE),
        .QUANTUM(QUANTUM),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .req(req),
        .wrap_clr(wrap_clr),
        .grant(grant),
        .grant_vld(grant_vld),
        .val1(val1),
        .val2(val2),
        .val3(val3),
        .val4(val4),
        .wrap(wrap),
        .sum(sum)
`ifdef COUNTER_RR_SCHED_STARVE_MON_EN
        ,
        .starve(starve)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input int v1, input int v2,
                           input int v3, input int v4, input logic [3:0] w, input int s);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".grant_vld"}, 32'(grant_vld), 32'(|g));
        chk({tag, ".val1"}, 32'(val1), 32'(v1));
        chk({tag, ".val2"}, 32'(val2), 32'(v2));
        chk({tag, ".val3"}, 32'(val3), 32'(v3));
        chk({tag, ".val4"}, 32'(val4), 32'(v4));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
        chk({tag, ".sum"}, 32'(sum), 32'(s));
    endtask

    // Drive inputs at the negedge, let one rising edge pass, return at the next negedge.
    task automatic cyc(input logic e, input logic [3:0] r, input logic c);
        en       = e;
        req      = r;
        wrap_clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en       = 1'b0;
        req      = 4'b0000;
        wrap_clr = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Grant a single requester for exactly n increments, then release it.
    task automatic load(input int idx, input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 4'(1 << idx), 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
    endtask

    // Reference model: one winner at a time, each grant cycle with en high adds one to its counter.
    int         m_cnt[4];
    int         m_mod[4] = '{256, 16, 16, 4};
    logic [3:0] m_wrap;
    int         m_sum;
    bit         m_busy;
    int         m_w;
    int         m_run;
    int         m_ptr;

    function automatic int m_pick(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return from;
    endfunction

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_busy) g[m_w] = 1'b1;
        return g;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        m_wrap = 4'b0000;
        m_sum  = 0;
        m_busy = 0;
        m_w    = 0;
        m_run  = 0;
        m_ptr  = 0;
    endfunction

    function automatic void m_step(input logic e, input logic [3:0] r, input logic c);
        logic [3:0] set_bits;
        set_bits = 4'b0000;
        m_sum = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
        if (m_busy && e) begin
            if (m_cnt[m_w] == m_mod[m_w] - 1) set_bits[m_w] = 1'b1;
            m_cnt[m_w] = (m_cnt[m_w] + 1) % m_mod[m_w];
        end
        m_wrap = (c ? 4'b0000 : m_wrap) | set_bits;
        if (!e) begin
            if (m_busy) m_ptr = (m_w + 1) % 4;
            m_busy = 0;
        end else if (!m_busy) begin
            if (r != 0) begin
                m_w    = m_pick(r, m_ptr);
                m_busy = 1;
                m_run  = 1;
            end
        end else if (r[m_w] && m_run < QUANTUM) begin
            m_run++;
        end else begin
            m_ptr = (m_w + 1) % 4;
            if (r != 0) begin
                m_w   = m_pick(r, m_ptr);
                m_run = 1;
            end else begin
                m_busy = 0;
            end
        end
    endfunction

    typedef struct {
        logic       e;
        logic [3:0] r;
        logic       c;
        logic [3:0] g;
        int         v1;
        int         v2;
        int         v3;
        int         v4;
        int         s;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2, 0, 0, 0, 1};
        tbl[3] = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2, 1, 0, 0, 2};
        tbl[4] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2, 2, 0, 0, 3};
        tbl[5] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2, 2, 1, 0, 4};
        tbl[6] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2, 2, 2, 0, 5};
        tbl[7] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2, 2, 2, 1, 6};
        tbl[8] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2, 2, 2, 2, 7};
        tbl[9] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 3, 2, 2, 2, 8};

        do_reset();
        chk_out("reset", 4'b0000, 0, 0, 0, 0, 4'b0000, 0);

        // Full contention from reset
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].e, tbl[i].r, tbl[i].c);
            chk_out($sformatf("contend[%0d]", i), tbl[i].g, tbl[i].v1, tbl[i].v2, tbl[i].v3,
                    tbl[i].v4, 4'b0000, tbl[i].s);
        end

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'b0000, 1'b0);
            chk("post_rst.grant", 32'(grant), 32'(0));
        end

        // Single requester wraps its counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 4'b0010, 1'b0);
            chk($sformatf("single.grant[%0d]", i), 32'(grant), 32'(4'b0010));
        end
        chk("single.val2", 32'(val2), 32'(0));
        chk("single.wrap", 32'(wrap), 32'(4'b0010));
        cyc(1'b1, 4'b0010, 1'b1);
        chk("wrap_clr.wrap", 32'(wrap), 32'(0));
        chk("wrap_clr.val2", 32'(val2), 32'(1));
        for (int i = 0; i < 14; i++) cyc(1'b1, 4'b0010, 1'b0);
        chk("pre_wrap.val2", 32'(val2), 32'(15));
        cyc(1'b1, 4'b0010, 1'b1);
        chk("set_beats_clr.wrap", 32'(wrap), 32'(4'b0010));
        chk("set_beats_clr.val2", 32'(val2), 32'(0));

        // Early release, then pointer advanced past the previous winner
        do_reset();
        cyc(1'b1, 4'b0001, 1'b0);
        chk("early.grant", 32'(grant), 32'(4'b0001));
        cyc(1'b1, 4'b0000, 1'b0);
        chk("early.idle_grant", 32'(grant), 32'(0));
        chk("early.val1", 32'(val1), 32'(1));
        cyc(1'b1, 4'b0000, 1'b0);
        chk("early.hold_val1", 32'(val1), 32'(1));
        cyc(1'b1, 4'b0011, 1'b0);
        chk("early.next_grant", 32'(grant), 32'(4'b0010));

        // Enable drop during a grant
        do_reset();
        cyc(1'b1, 4'b1111, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        chk("endrop.pre_grant", 32'(grant), 32'(4'b0001));
        cyc(1'b0, 4'b1111, 1'b0);
        chk("endrop.grant", 32'(grant), 32'(0));
        chk("endrop.val1", 32'(val1), 32'(1));
        cyc(1'b0, 4'b1111, 1'b0);
        chk("endrop.frozen", 32'(val1), 32'(1));
        cyc(1'b1, 4'b1111, 1'b0);
        chk("endrop.resume_grant", 32'(grant), 32'(4'b0010));
        chk("endrop.resume_val1", 32'(val1), 32'(1));

        // Sum at maximum counter values
        do_reset();
        load(0, 255);
        load(1, 15);
        load(2, 15);
        load(3, 3);
        chk("sumb.lag", 32'(sum), 32'(287));
        cyc(1'b1, 4'b0000, 1'b0);
        chk_out("sumb", 4'b0000, 255, 15, 15, 3, 4'b0000, 288);

`ifdef COUNTER_RR_SCHED_STARVE_MON_EN
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1'b0, 4'b0001, 1'b0);
        chk("starve.below", 32'(starve), 32'(0));
        cyc(1'b0, 4'b0001, 1'b0);
        chk("starve.hit", 32'(starve), 32'(4'b0001));
        cyc(1'b0, 4'b0001, 1'b0);
        chk("starve.sat", 32'(starve), 32'(4'b0001));
        cyc(1'b0, 4'b0000, 1'b0);
        chk("starve.clear", 32'(starve), 32'(0));
`endif

        // Randomized comparison against the reference model
        do_reset();
        m_reset();
        for (int i = 0; i < 600; i++) begin
            logic       e;
            logic [3:0] r;
            logic       c;
            e = ($urandom_range(0, 9) != 0);
            r = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 15) == 0);
            m_step(e, r, c);
            cyc(e, r, c);
            chk_out($sformatf("rand[%0d]", i), m_grant(), m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3],
                    m_wrap, m_sum);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_rr_sched.md
Name: counter_rr_sched

Overview:
- Single-clock round-robin scheduler that owns four counters of widths SIZE, SIZE/2, SIZE/2 and SIZE/4, plus a registered sum of all four.
- Replaces the derived-clock selector scheme. Counters are shared on one clock and advanced only when the arbiter grants an increment to a requester.
- Sits between requester logic and any consumer of the counter values or their sum.

Parameters:
- SIZE, 8, width of counter 1. Must be a multiple of 4 and at least 4. Counters 2 and 3 are SIZE/2 wide; counter 4 is SIZE/4 wide.
- QUANTUM, 2, maximum consecutive grant cycles per winner before rotation. Range 1..15.
- STARVE_LIMIT, 16, wait threshold used by the optional starvation monitor.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low. Asserting rst=0 clears all state immediately; deassertion is synchronous to clk.
- en  input  1  global scheduling enable.
- req  input  4  increment request; bit i belongs to counter i+1.
- wrap_clr  input  1  clears all sticky wrap flags.
- grant  output  4  one-hot registered grant, or all zeros.
- grant_vld  output  1  equals OR of grant.
- val1  output  SIZE  counter 1.
- val2  output  SIZE/2  counter 2.
- val3  output  SIZE/2  counter 3.
- val4  output  SIZE/4  counter 4.
- wrap  output  4  sticky wrap flags, one per counter.
- sum  output  2*SIZE  registered sum of the four counters.

Behaviour:
- Reset values: grant=0, grant_vld=0, val1..val4=0, wrap=0, sum=0. Internal state: FSM=IDLE, ptr=0, qcnt=0.
- FSM state IDLE:
  - grant=0.
  - If en=1 and req!=0, pick winner w = first set req bit searching cyclically from ptr. Next cycle: BUSY, grant=onehot(w), qcnt=1.
  - Grant latency is one cycle from the req sample.
- FSM state BUSY:
  - Every cycle in BUSY, counter w+1 increments by 1.
  - Stay on w (qcnt++) if en=1, req[w]=1 and qcnt<QUANTUM.
  - Otherwise set ptr=(w+1) mod 4 and re-arbitrate in the same cycle, searching from the new ptr:
    - if en=1 and req!=0, grant the new winner back-to-back with qcnt=1; the same w may win again if it is the only requester;
    - else go to IDLE with grant=0 next cycle.
- en=0 in any state: grant=0 from the next cycle, FSM goes to IDLE, counters hold.
- Counter wrap:
  - Counters wrap modulo 2^width.
  - An increment from all-ones sets wrap[i] on the same edge.
  - wrap_clr=1 clears all flags. A simultaneous set on the same edge wins over the clear for that bit.
- Sum:
  - sum <= zero-extended val1+val2+val3+val4, registered.
  - Reflects counter values one cycle after they change; no overflow is possible at 2*SIZE width.
- Counters change only while granted; no other path modifies them except reset.

Optional Feature:
- Macro: COUNTER_RR_SCHED_STARVE_MON_EN.
- With the macro defined:
  - Adds output starve[3:0] and four wait counters, each saturating at STARVE_LIMIT.
  - wait_i increments each cycle that req[i]=1 and grant[i]=0; it clears when grant[i]=1 or req[i]=0.
  - starve[i]=1 while wait_i>=STARVE_LIMIT.
  - Reset value of starve is 0.
- Without the macro: no starve port and no monitor logic. All other behaviour is identical.

Test Plan (all scenarios use SIZE=8, QUANTUM=2):
- Reset: drive rst=0 mid-run at an arbitrary time -> all outputs 0 immediately, without waiting for a clk edge. After rst=1 with req=0: grant stays 0.
- Full contention: en=1, req=4'b1111 held from reset -> grant sequence 0000,0001,0001,0010,0010,0100,0100,1000,1000,0001,... After 8 grant cycles, val1..val4=2 and sum=8 one cycle later.
- Single requester: req=4'b0010 held -> grant=0010 continuously. After 16 grants val2=0 and wrap=4'b0010. wrap_clr pulse -> wrap=0.
- Early release: req=4'b0001 for one cycle only -> exactly one grant=0001 cycle, val1=1, FSM returns to IDLE. Next req=4'b0011 -> winner is requester 1 (ptr=1), grant=0010.
- Enable drop: req=4'b1111, en falls during a grant -> grant=0 on the next cycle and counters frozen. en=1 again -> arbitration resumes from ptr=(w+1).
- Sum boundary: preload by granting until val1=255, val2=15, val3=15, val4=3 -> sum=288 (0x0120) one cycle after the last increment. With the macro defined, en=0 and req=4'b0001 held for 16 cycles -> starve=4'b0001.
